// File: rtl/rob_alloc_commit_if.sv
// Allocation, completion and commit signals between the rename stage, execute ports and the ROB.
// The ROB takes the slave modport; the producer and consumer side takes the master modport.
interface rob_alloc_commit_if #(
  parameter int PTR_W = 4
);
  logic                 alloc_req;
  logic [3:0]           inst_val;
  logic [3:0]           str_en;
  logic [3:0]           spec_brch;
  logic [7:0]           brch_mode;
  logic [3:0]           brch_pred_res;
  logic [3:0]           no_exe;
  logic [3:0]           jr;
  logic [63:0]          rcvr_pc;
  logic                 alloc_ready;
  logic [4*PTR_W-1:0]   alloc_idx;
  logic [1:0]           cmpl_vld;
  logic [2*PTR_W-1:0]   cmpl_idx;
  logic [1:0]           cmpl_taken;
  logic [31:0]          cmpl_tgt;
  logic [3:0]           commit_vld;
  logic [3:0]           commit_str;
  logic                 flush;
  logic [15:0]          flush_pc;
  logic [PTR_W:0]       rob_count;

  modport master (
    output alloc_req, inst_val, str_en, spec_brch, brch_mode, brch_pred_res, no_exe, jr, rcvr_pc,
    output cmpl_vld, cmpl_idx, cmpl_taken, cmpl_tgt,
    input  alloc_ready, alloc_idx, commit_vld, commit_str, flush, flush_pc, rob_count
  );

  modport slave (
    input  alloc_req, inst_val, str_en, spec_brch, brch_mode, brch_pred_res, no_exe, jr, rcvr_pc,
    input  cmpl_vld, cmpl_idx, cmpl_taken, cmpl_tgt,
    output alloc_ready, alloc_idx, commit_vld, commit_str, flush, flush_pc, rob_count
  );
endinterface

// File: rtl/rob_alloc_commit.sv
// Reorder buffer: 4-wide allocate, 2 completion ports, up to 4 in-order commits per cycle.
// Commit and flush are combinational from registered state; allocation stalls while < 4 entries are free or flushing.
module rob_alloc_commit #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input logic               clk,
  input logic               rst,
  rob_alloc_commit_if.slave rob
);
  logic [DEPTH-1:0] occ_q, occ_d, done_q, done_d;
  logic [DEPTH-1:0] val_q, val_d, str_q, str_d, spec_q, spec_d;
  logic [DEPTH-1:0] pred_q, pred_d, jr_q, jr_d, taken_q, taken_d;
  logic [15:0]      rpc_q [DEPTH];
  logic [15:0]      rpc_d [DEPTH];
  logic [15:0]      tgt_q [DEPTH];
  logic [15:0]      tgt_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [PTR_W-1:0]   win_idx  [4];
  logic [PTR_W-1:0]   slot_idx [4];
  logic [4*PTR_W-1:0] alloc_idx_w;
  logic [3:0]         retire;
  logic [2:0]         n_ret;
  logic               chain;
  logic               cflush;
  logic [15:0]        cflush_pc;
  logic               alloc_rdy;
  logic               accept;
  logic [PTR_W-1:0]   c_idx;

  // Retire scan: stop at the first entry that is not ready, and just after a flushing entry.
  always_comb begin
    retire      = '0;
    n_ret       = '0;
    chain       = 1'b1;
    cflush      = 1'b0;
    cflush_pc   = '0;
    alloc_idx_w = '0;
    for (int k = 0; k < 4; k++) begin
      win_idx[k]  = head_q + PTR_W'(k);
      slot_idx[k] = tail_q + PTR_W'(k);
      alloc_idx_w[k*PTR_W +: PTR_W] = slot_idx[k];
      if (chain && ((PTR_W+1)'(k) < count_q) && occ_q[win_idx[k]] && done_q[win_idx[k]]) begin
        retire[k] = 1'b1;
        n_ret     = n_ret + 3'd1;
        if (jr_q[win_idx[k]]) begin
          cflush    = 1'b1;
          cflush_pc = tgt_q[win_idx[k]];
          chain     = 1'b0;
        end else if (spec_q[win_idx[k]] && (taken_q[win_idx[k]] != pred_q[win_idx[k]])) begin
          cflush    = 1'b1;
          cflush_pc = rpc_q[win_idx[k]];
          chain     = 1'b0;
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

  assign alloc_rdy = (count_q <= (PTR_W+1)'(DEPTH - 4)) && !cflush;
  assign accept    = rob.alloc_req && alloc_rdy;

  always_comb begin
    rob.commit_vld = '0;
    rob.commit_str = '0;
    for (int k = 0; k < 4; k++) begin
      rob.commit_vld[k] = retire[k] && val_q[win_idx[k]] && !rst;
      rob.commit_str[k] = retire[k] && val_q[win_idx[k]] && str_q[win_idx[k]] && !rst;
    end
  end

  assign rob.flush       = cflush && !rst;
  assign rob.flush_pc    = (cflush && !rst) ? cflush_pc : 16'h0000;
  assign rob.alloc_ready = alloc_rdy;
  assign rob.alloc_idx   = alloc_idx_w;
  assign rob.rob_count   = count_q;

  always_comb begin
    occ_d   = occ_q;
    done_d  = done_q;
    val_d   = val_q;
    str_d   = str_q;
    spec_d  = spec_q;
    pred_d  = pred_q;
    jr_d    = jr_q;
    taken_d = taken_q;
    rpc_d   = rpc_q;
    tgt_d   = tgt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    c_idx   = '0;

    // Port 1 is applied last so it wins when both ports name the same entry.
    for (int p = 0; p < 2; p++) begin
      c_idx = rob.cmpl_idx[p*PTR_W +: PTR_W];
      if (rob.cmpl_vld[p] && occ_q[c_idx] && !done_q[c_idx]) begin
        done_d[c_idx]  = 1'b1;
        taken_d[c_idx] = rob.cmpl_taken[p];
        tgt_d[c_idx]   = rob.cmpl_tgt[16*p +: 16];
      end
    end

    for (int k = 0; k < 4; k++) begin
      if (retire[k]) begin
        occ_d[win_idx[k]]  = 1'b0;
        done_d[win_idx[k]] = 1'b0;
      end
    end
    head_d  = head_q + PTR_W'(n_ret);
    count_d = count_q - (PTR_W+1)'(n_ret);

    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        occ_d[slot_idx[i]]  = 1'b1;
        done_d[slot_idx[i]] = !rob.inst_val[i] || rob.no_exe[i];
        val_d[slot_idx[i]]  = rob.inst_val[i];
        str_d[slot_idx[i]]  = rob.str_en[i];
        spec_d[slot_idx[i]] = rob.spec_brch[i];
        pred_d[slot_idx[i]] = rob.brch_pred_res[i];
        jr_d[slot_idx[i]]   = rob.jr[i];
        rpc_d[slot_idx[i]]  = rob.rcvr_pc[16*i +: 16];
      end
      tail_d  = tail_q + PTR_W'(4);
      count_d = count_d + (PTR_W+1)'(4);
    end

    // brch_mode travels with the bundle but nothing downstream of commit consumes it.
    if (cflush) begin
      occ_d   = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      occ_q   <= occ_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload is qualified by occ/done, so it needs no reset.
  always_ff @(posedge clk) begin
    val_q   <= val_d;
    str_q   <= str_d;
    spec_q  <= spec_d;
    pred_q  <= pred_d;
    jr_q    <= jr_d;
    taken_q <= taken_d;
    rpc_q   <= rpc_d;
    tgt_q   <= tgt_d;
  end
endmodule

// File: tb/tb_rob_alloc_commit.sv
// Table-driven bench for rob_alloc_commit: each row holds one cycle of inputs and the outputs expected in that cycle.
module tb_rob_alloc_commit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rob_alloc_commit_if #(.PTR_W(4)) bus ();
  rob_alloc_commit #(.DEPTH(16), .PTR_W(4)) dut (.clk(clk), .rst(rst), .rob(bus));

  typedef struct {
    logic        r;
    logic        areq;
    logic [3:0]  iv, ne, se, sb, pr, jr;
    logic [63:0] rpc;
    logic [1:0]  cv;
    logic [7:0]  ci;
    logic [1:0]  ct;
    logic [31:0] tgt;
    logic        e_rdy;
    logic [15:0] e_idx;
    logic [3:0]  e_cv, e_cs;
    logic        e_fl;
    logic [15:0] e_pc;
    logic [4:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  vec_t cur;
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t idle_vec();
    vec_t v;
    v.r = 1'b0; v.areq = 1'b0;
    v.iv = '0; v.ne = '0; v.se = '0; v.sb = '0; v.pr = '0; v.jr = '0; v.rpc = '0;
    v.cv = '0; v.ci = '0; v.ct = '0; v.tgt = '0;
    v.e_rdy = 1'b0; v.e_idx = '0; v.e_cv = '0; v.e_cs = '0; v.e_fl = 1'b0; v.e_pc = '0; v.e_cnt = '0;
    return v;
  endfunction

  task automatic al(input logic [3:0] iv, input logic [3:0] ne, input logic [3:0] se, input logic [3:0] sb,
                    input logic [3:0] pr, input logic [3:0] jr, input logic [63:0] rpc);
    cur.areq = 1'b1; cur.iv = iv; cur.ne = ne; cur.se = se; cur.sb = sb; cur.pr = pr; cur.jr = jr; cur.rpc = rpc;
  endtask

  task automatic cm(input logic [1:0] v, input logic [7:0] i, input logic [1:0] t, input logic [31:0] g);
    cur.cv = v; cur.ci = i; cur.ct = t; cur.tgt = g;
  endtask

  task automatic ex(input logic rdy, input logic [15:0] idx, input logic [3:0] cvv, input logic [3:0] cs,
                    input logic fl, input logic [15:0] pc, input logic [4:0] cnt);
    cur.e_rdy = rdy; cur.e_idx = idx; cur.e_cv = cvv; cur.e_cs = cs; cur.e_fl = fl; cur.e_pc = pc; cur.e_cnt = cnt;
    tbl.push_back(cur);
    cur = idle_vec();
  endtask

  // Reset row: only "no commit, no flush" is required of the outputs.
  task automatic rs();
    cur.r = 1'b1;
    tbl.push_back(cur);
    cur = idle_vec();
  endtask

  task automatic drive(input vec_t v);
    rst               = v.r;
    bus.alloc_req     = v.areq;
    bus.inst_val      = v.iv;
    bus.no_exe        = v.ne;
    bus.str_en        = v.se;
    bus.spec_brch     = v.sb;
    bus.brch_pred_res = v.pr;
    bus.jr            = v.jr;
    bus.rcvr_pc       = v.rpc;
    bus.brch_mode     = 8'hA5;
    bus.cmpl_vld      = v.cv;
    bus.cmpl_idx      = v.ci;
    bus.cmpl_taken    = v.ct;
    bus.cmpl_tgt      = v.tgt;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    vec_t e;
    cur = idle_vec();
    drive(idle_vec());
    rst = 1'b1;

    // All-no-execute bundle commits the next cycle.
    rs(); rs();
    al(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0);  ex(1'b1, 16'h3210, 4'h0, 4'h0, 1'b0, 16'h0, 5'd0);
    ex(1'b1, 16'h7654, 4'hF, 4'h0, 1'b0, 16'h0, 5'd4);
    ex(1'b1, 16'h7654, 4'h0, 4'h0, 1'b0, 16'h0, 5'd0);

    // Fill to full, drop a bundle while full, complete 0..3 out of order.
    rs();
    al(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0);  ex(1'b1, 16'h3210, 4'h0, 4'h0, 1'b0, 16'h0, 5'd0);
    al(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0);  ex(1'b1, 16'h7654, 4'h0, 4'h0, 1'b0, 16'h0, 5'd4);
    al(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0);  ex(1'b1, 16'hBA98, 4'h0, 4'h0, 1'b0, 16'h0, 5'd8);
    al(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0);  ex(1'b1, 16'hFEDC, 4'h0, 4'h0, 1'b0, 16'h0, 5'd12);
    al(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0);  cm(2'b11, 8'h21, 2'b00, 32'h0);
    ex(1'b0, 16'h3210, 4'h0, 4'h0, 1'b0, 16'h0, 5'd16);
    cm(2'b11, 8'h30, 2'b00, 32'h0);                 ex(1'b0, 16'h3210, 4'h0, 4'h0, 1'b0, 16'h0, 5'd16);
    ex(1'b0, 16'h3210, 4'hF, 4'h0, 1'b0, 16'h0, 5'd16);
    al(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0);  ex(1'b1, 16'h3210, 4'h0, 4'h0, 1'b0, 16'h0, 5'd12);
    ex(1'b0, 16'h7654, 4'h0, 4'h0, 1'b0, 16'h0, 5'd16);

    // Out-of-order completion holds commit; invalid slots retire silently.
    rs();
    al(4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0);  ex(1'b1, 16'h3210, 4'h0, 4'h0, 1'b0, 16'h0, 5'd0);
    cm(2'b01, 8'h01, 2'b00, 32'h0);                 ex(1'b1, 16'h7654, 4'h0, 4'h0, 1'b0, 16'h0, 5'd4);
    ex(1'b1, 16'h7654, 4'h0, 4'h0, 1'b0, 16'h0, 5'd4);
    cm(2'b01, 8'h00, 2'b00, 32'h0);                 ex(1'b1, 16'h7654, 4'h0, 4'h0, 1'b0, 16'h0, 5'd4);
    ex(1'b1, 16'h7654, 4'h3, 4'h0, 1'b0, 16'h0, 5'd4);
    ex(1'b1, 16'h7654, 4'h0, 4'h0, 1'b0, 16'h0, 5'd0);

    // Branch mispredict flush; the bundle offered in the flush cycle is dropped.
    rs();
    al(4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 64'h00A4); ex(1'b1, 16'h3210, 4'h0, 4'h0, 1'b0, 16'h0, 5'd0);
    cm(2'b01, 8'h00, 2'b00, 32'h0);                   ex(1'b1, 16'h7654, 4'h0, 4'h0, 1'b0, 16'h0, 5'd4);
    al(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0);    ex(1'b0, 16'h7654, 4'h1, 4'h0, 1'b1, 16'h00A4, 5'd4);
    ex(1'b1, 16'h3210, 4'h0, 4'h0, 1'b0, 16'h0, 5'd0);

    // Store commit, correct prediction, then jr redirect to the completed target.
    rs();
    al(4'hF, 4'h0, 4'h2, 4'h4, 4'h4, 4'h8, 64'hBEEF_0000_0000_0000); ex(1'b1, 16'h3210, 4'h0, 4'h0, 1'b0, 16'h0, 5'd0);
    cm(2'b11, 8'h10, 2'b00, 32'h0);                 ex(1'b1, 16'h7654, 4'h0, 4'h0, 1'b0, 16'h0, 5'd4);
    cm(2'b11, 8'h32, 2'b01, 32'h1230_0000);         ex(1'b1, 16'h7654, 4'h3, 4'h2, 1'b0, 16'h0, 5'd4);
    ex(1'b0, 16'h7654, 4'h3, 4'h0, 1'b1, 16'h1230, 5'd2);
    ex(1'b1, 16'h3210, 4'h0, 4'h0, 1'b0, 16'h0, 5'd0);

    // Five bundles wrap the pointers, then dual completions where port 1 must win.
    rs();
    al(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0);  ex(1'b1, 16'h3210, 4'h0, 4'h0, 1'b0, 16'h0, 5'd0);
    al(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0);  ex(1'b1, 16'h7654, 4'hF, 4'h0, 1'b0, 16'h0, 5'd4);
    al(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0);  ex(1'b1, 16'hBA98, 4'hF, 4'h0, 1'b0, 16'h0, 5'd4);
    al(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0);  ex(1'b1, 16'hFEDC, 4'hF, 4'h0, 1'b0, 16'h0, 5'd4);
    al(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0);  ex(1'b1, 16'h3210, 4'hF, 4'h0, 1'b0, 16'h0, 5'd4);
    ex(1'b1, 16'h7654, 4'hF, 4'h0, 1'b0, 16'h0, 5'd4);
    al(4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 64'h0055); ex(1'b1, 16'h7654, 4'h0, 4'h0, 1'b0, 16'h0, 5'd0);
    cm(2'b11, 8'h44, 2'b10, 32'h0);                 ex(1'b1, 16'hBA98, 4'h0, 4'h0, 1'b0, 16'h0, 5'd4);
    ex(1'b0, 16'hBA98, 4'h1, 4'h0, 1'b1, 16'h0055, 5'd4);
    al(4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 64'h0);  ex(1'b1, 16'h3210, 4'h0, 4'h0, 1'b0, 16'h0, 5'd0);
    cm(2'b11, 8'h00, 2'b00, 32'h2222_1111);         ex(1'b1, 16'h7654, 4'h0, 4'h0, 1'b0, 16'h0, 5'd4);
    ex(1'b0, 16'h7654, 4'h1, 4'h0, 1'b1, 16'h2222, 5'd4);
    ex(1'b1, 16'h3210, 4'h0, 4'h0, 1'b0, 16'h0, 5'd0);

    // Reset while a commit is pending suppresses it and empties the ROB.
    al(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0);  ex(1'b1, 16'h3210, 4'h0, 4'h0, 1'b0, 16'h0, 5'd0);
    rs();
    ex(1'b1, 16'h3210, 4'h0, 4'h0, 1'b0, 16'h0, 5'd0);

    for (int n = 0; n < tbl.size(); n++) begin
      @(posedge clk);
      #1;
      drive(tbl[n]);
      exp_q.push_back(tbl[n]);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("r%0d_commit_vld", n), 32'(bus.commit_vld), 32'(e.e_cv));
      chk($sformatf("r%0d_flush", n), 32'(bus.flush), 32'(e.e_fl));
      if (!e.r) begin
        chk($sformatf("r%0d_commit_str", n), 32'(bus.commit_str), 32'(e.e_cs));
        chk($sformatf("r%0d_flush_pc", n), 32'(bus.flush_pc), 32'(e.e_pc));
        chk($sformatf("r%0d_alloc_ready", n), 32'(bus.alloc_ready), 32'(e.e_rdy));
        chk($sformatf("r%0d_alloc_idx", n), 32'(bus.alloc_idx), 32'(e.e_idx));
        chk($sformatf("r%0d_rob_count", n), 32'(bus.rob_count), 32'(e.e_cnt));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
